// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants and helpers for the multi-digit BCD scan counter:
// seven-segment decode, integer-to-BCD image and BCD validity check.
package bcd_scan_counter_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Elaboration-time conversion; upper nibbles beyond the used decades come out zero.
  function automatic logic [31:0] to_bcd(input int value);
    logic [31:0] r;
    int          v;
    r = '0;
    v = value;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [31:0] v);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_decade.sv
// One BCD decade: sync load, increment with carry chain, decrement with borrow chain.
module bcd_decade (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] q_o,
  output logic       carry_o,
  output logic       borrow_o
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load_i)
      digit_d = load_val_i;
    else if (inc_i)
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    else if (dec_i)
      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) digit_q <= 4'd0;
    else      digit_q <= digit_d;
  end

  assign q_o      = digit_q;
  assign carry_o  = inc_i & (digit_q == 4'd9);
  assign borrow_o = dec_i & (digit_q == 4'd0);

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with prescaler, terminal-count wrap, guarded load
// and time-multiplexed seven-segment drive (shared segment bus, one-hot digit enables).
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int MAX_COUNT = 9999,
  parameter int TICK_DIV  = 1,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_LZ  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_bcd,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int BW = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [BW-1:0] MAX_BCD = BW'(to_bcd(MAX_COUNT));

  logic [BW-1:0]     count_q;
  logic [DIGITS:0]   carry, borrow;
  logic [PW-1:0]     presc_q, presc_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              wrap_q;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] den_q, den_d;

  logic              tick, load_ok, at_max, at_zero, wrap_up, wrap_dn;
  logic              dec_load;
  logic [BW-1:0]     dec_val;
  logic              unused_chain_top;

  assign tick    = en & (presc_q == PW'(TICK_DIV - 1));
  assign load_ok = load & bcd_valid(32'(load_bcd)) & (load_bcd <= MAX_BCD);
  assign at_max  = (count_q == MAX_BCD);
  assign at_zero = (count_q == '0);
  assign wrap_up = tick &  up & at_max  & ~load_ok;
  assign wrap_dn = tick & ~up & at_zero & ~load_ok;

  // Terminal wrap reuses the decade load path so the chain never has to roll over itself.
  assign dec_load  = load_ok | wrap_up | wrap_dn;
  assign dec_val   = load_ok ? load_bcd : (wrap_up ? '0 : MAX_BCD);
  assign carry[0]  = tick &  up & ~at_max  & ~load_ok;
  assign borrow[0] = tick & ~up & ~at_zero & ~load_ok;

  // Carry/borrow out of the top decade cannot occur: the terminal checks catch it first.
  assign unused_chain_top = carry[DIGITS] | borrow[DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_decade
    bcd_decade u_decade (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (carry[k]),
      .dec_i      (borrow[k]),
      .load_i     (dec_load),
      .load_val_i (dec_val[4*k +: 4]),
      .q_o        (count_q[4*k +: 4]),
      .carry_o    (carry[k+1]),
      .borrow_o   (borrow[k+1])
    );
  end

  always_comb begin
    presc_d = presc_q;
    if (load_ok)
      presc_d = '0;
    else if (en)
      presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  logic [DIGITS-1:0] lz;
  logic              hz;
  logic [3:0]        nib;
  logic              blank_sel;

  // lz[k]: decade k and everything above it are zero
  always_comb begin
    hz = 1'b1;
    lz = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hz    = hz & (count_q[4*k +: 4] == 4'd0);
      lz[k] = hz;
    end
  end

  always_comb begin
    nib       = 4'd0;
    den_d     = '0;
    blank_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib       = count_q[4*k +: 4];
        den_d[k]  = 1'b1;
        blank_sel = lz[k];
      end
    end
    seg_d = ((BLANK_LZ != 0) && blank_sel) ? SEG_BLANK : seg_decode(nib);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      seg_q   <= SEG_0;
      den_q   <= DIGITS'(1);
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_up | wrap_dn;
      seg_q   <= seg_d;
      den_q   <= den_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign segments  = seg_q;
  assign digit_en  = den_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter (2 digits, max 59, tick /4, scan /2): directed steps
// then random traffic, all checked against an integer-level reference model.
module tb_bcd_scan_counter;

  localparam int DIGITS    = 2;
  localparam int MAX_COUNT = 59;
  localparam int TICK_DIV  = 4;
  localparam int SCAN_DIV  = 2;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [7:0] load_bcd;
  logic [7:0] count_bcd, count_bcd_nb;
  logic       wrap, wrap_nb;
  logic [6:0] segments, segments_nb;
  logic [1:0] digit_en, digit_en_nb;

  always #5 clk = ~clk;

  bcd_scan_counter #(.DIGITS(DIGITS), .MAX_COUNT(MAX_COUNT), .TICK_DIV(TICK_DIV),
                     .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bcd(load_bcd),
    .count_bcd(count_bcd), .wrap(wrap), .segments(segments), .digit_en(digit_en));

  bcd_scan_counter #(.DIGITS(DIGITS), .MAX_COUNT(MAX_COUNT), .TICK_DIV(TICK_DIV),
                     .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bcd(load_bcd),
    .count_bcd(count_bcd_nb), .wrap(wrap_nb), .segments(segments_nb), .digit_en(digit_en_nb));

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int         m_cnt, m_presc, m_scan, m_idx;
  bit         m_wrap;
  logic [1:0] m_den;
  logic [6:0] m_seg, m_seg_nb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int cnt, input int idx, input bit blank);
    int d;
    d = (idx == 0) ? cnt % 10 : cnt / 10;
    if (blank && idx > 0 && cnt < 10) return 7'h00;
    return seg_tab[d];
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_presc = 0; m_scan = 0; m_idx = 0; m_wrap = 0;
    m_den = 2'b01; m_seg = 7'h3F; m_seg_nb = 7'h3F;
  endtask

  // One clock: predict from pre-edge state and inputs, then compare just after the edge.
  task automatic cycle();
    int         n_cnt, n_presc, n_scan, n_idx, ld_val;
    bit         n_wrap, ld_ok, tk;
    logic [1:0] n_den;
    logic [6:0] n_seg, n_seg_nb;
    n_seg    = exp_seg(m_cnt, m_idx, 1'b1);
    n_seg_nb = exp_seg(m_cnt, m_idx, 1'b0);
    n_den    = (m_idx == 0) ? 2'b01 : 2'b10;
    ld_val   = load_bcd[7:4] * 10 + load_bcd[3:0];
    ld_ok    = load && load_bcd[7:4] <= 9 && load_bcd[3:0] <= 9 && ld_val <= MAX_COUNT;
    tk       = en && (m_presc == TICK_DIV - 1);
    n_cnt = m_cnt; n_presc = m_presc; n_wrap = 0;
    if (ld_ok) begin
      n_cnt = ld_val; n_presc = 0;
    end else if (tk) begin
      n_presc = 0;
      if (up) begin
        if (m_cnt == MAX_COUNT) begin n_cnt = 0; n_wrap = 1; end
        else n_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin n_cnt = MAX_COUNT; n_wrap = 1; end
        else n_cnt = m_cnt - 1;
      end
    end else if (en) begin
      n_presc = m_presc + 1;
    end
    if (m_scan == SCAN_DIV - 1) begin n_scan = 0; n_idx = (m_idx + 1) % DIGITS; end
    else begin n_scan = m_scan + 1; n_idx = m_idx; end
    @(posedge clk);
    #1;
    if (!rst) model_reset();
    else begin
      m_cnt = n_cnt; m_presc = n_presc; m_wrap = n_wrap; m_scan = n_scan; m_idx = n_idx;
      m_den = n_den; m_seg = n_seg; m_seg_nb = n_seg_nb;
    end
    chk("count",       count_bcd,    to_bcd8(m_cnt));
    chk("wrap",        wrap,         m_wrap);
    chk("digit_en",    digit_en,     m_den);
    chk("segments",    segments,     m_seg);
    chk("count_nb",    count_bcd_nb, to_bcd8(m_cnt));
    chk("wrap_nb",     wrap_nb,      m_wrap);
    chk("digit_en_nb", digit_en_nb,  m_den);
    chk("segments_nb", segments_nb,  m_seg_nb);
  endtask

  // Run until the model reports a wrap, bounded; expiry is a failed comparison.
  task automatic run_to_wrap(input string tag);
    int guard;
    guard = 0;
    do begin
      cycle();
      guard++;
    end while (!m_wrap && guard < 3 * TICK_DIV);
    chk({tag, "_wrap_seen"}, wrap, 1'b1);
  endtask

  initial begin
    int guard;
    model_reset();
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_bcd = 8'h00;
    repeat (3) cycle();
    rst = 1'b1;
    chk("rst_count",    count_bcd, 8'h00);
    chk("rst_digit_en", digit_en,  2'b01);
    chk("rst_segments", segments,  7'h3F);
    chk("rst_wrap",     wrap,      1'b0);

    en = 1'b1; up = 1'b1;
    repeat (40) cycle();
    chk("prescale_count", count_bcd, 8'h10);

    load = 1'b1; load_bcd = 8'h59;
    cycle();
    load = 1'b0;
    chk("load59", count_bcd, 8'h59);
    run_to_wrap("up");
    chk("up_wrap_count", count_bcd, 8'h00);
    cycle();
    chk("up_wrap_one_cycle", wrap, 1'b0);

    up = 1'b0;
    run_to_wrap("down");
    chk("down_wrap_count", count_bcd, 8'h59);
    cycle();
    chk("down_wrap_one_cycle", wrap, 1'b0);

    en = 1'b0;
    load = 1'b1; load_bcd = 8'h6A;
    cycle();
    chk("load_bad_nibble", count_bcd, 8'h59);
    load_bcd = 8'h60;
    cycle();
    chk("load_over_max", count_bcd, 8'h59);
    load = 1'b0;

    en = 1'b1;
    guard = 0;
    while (m_presc != TICK_DIV - 1 && guard < 2 * TICK_DIV) begin
      cycle();
      guard++;
    end
    chk("presc_align", m_presc, TICK_DIV - 1);
    load = 1'b1; load_bcd = 8'h42;
    cycle();
    load = 1'b0;
    chk("load_tick_count", count_bcd, 8'h42);
    chk("load_tick_wrap",  wrap,      1'b0);
    repeat (3) cycle();
    chk("presc_restart", count_bcd, 8'h42);
    cycle();
    chk("first_tick_after_load", count_bcd, 8'h41);

    en = 1'b0;
    load = 1'b1; load_bcd = 8'h07;
    cycle();
    load = 1'b0;
    cycle();
    repeat (6) begin
      cycle();
      chk("scan_seg",    segments,    (m_den == 2'b01) ? 7'h07 : 7'h00);
      chk("scan_seg_nb", segments_nb, (m_den == 2'b01) ? 7'h07 : 7'h3F);
    end

    load = 1'b1; load_bcd = 8'h37;
    cycle();
    load = 1'b0;
    chk("pre_reset_count", count_bcd, 8'h37);
    rst = 1'b0;
    #1;
    chk("async_count",    count_bcd, 8'h00);
    chk("async_digit_en", digit_en,  2'b01);
    chk("async_segments", segments,  7'h3F);
    chk("async_wrap",     wrap,      1'b0);
    cycle();
    rst = 1'b1;
    en = 1'b1;

    repeat (500) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1) == 1;
      load = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) load_bcd = 8'($urandom);
      else load_bcd = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Parametrised multi-digit BCD up/down counter with programmable terminal count, tick prescaler, synchronous load and time-multiplexed seven-segment drive.
- Successor to the single-digit 0..5 counter/display pair; replaces counter + decoder at the top of the display path.
- Drives one shared segment bus plus one-hot digit enables for a DIGITS-wide common-cathode display.

Parameters:
- DIGITS, 4, number of BCD decades; legal 1..8.
- MAX_COUNT, 9999, terminal value as an integer; legal 1..10^DIGITS-1. Count range is 0..MAX_COUNT.
- TICK_DIV, 1, enabled clk cycles per count step; legal >=1.
- SCAN_DIV, 1000, clk cycles per digit scan slot; legal >=1.
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 never blanked).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  1 = prescaler runs; 0 = prescaler and count frozen.
- up  input  1  1 = count up, 0 = count down; sampled on each tick.
- load  input  1  synchronous load strobe.
- load_bcd  input  4*DIGITS  load value, nibble k = decade k (nibble 0 = units).
- count_bcd  output  4*DIGITS  current count, registered.
- wrap  output  1  one-cycle pulse on terminal wrap.
- segments  output  7  bit0=a .. bit6=g, active-high.
- digit_en  output  DIGITS  one-hot digit select, active-high, bit k = decade k.

Behaviour:
- Reset (rst=0, async): count_bcd=0, prescaler=0, wrap=0, scan counter=0, digit index=0, digit_en=1 (decade 0), segments=7'h3F.
- Prescaler: counts 0..TICK_DIV-1 while en=1. Tick = en & (prescaler==TICK_DIV-1), then the prescaler returns to 0. With TICK_DIV=1, every enabled cycle is a tick.
- Count step: applied on the clk edge where tick=1.
  - up=1: if count==MAX_COUNT, go to 0 and pulse wrap; else +1 with decimal carry (9->0, carry to next decade).
  - up=0: if count==0, go to MAX_COUNT and pulse wrap; else -1 with decimal borrow (0->9).
- wrap: high exactly the cycle after the wrapping edge, i.e. coincident with the new count_bcd value.
- Load: on load=1, count_bcd<=load_bcd and prescaler<=0.
  - Load is ignored (count and prescaler untouched) if any nibble >9 or the value exceeds MAX_COUNT in BCD.
  - Load has priority over a coincident tick. That tick is lost and wrap does not pulse.
  - Load is honoured when en=0.
- en=0: prescaler holds its value; the count holds; scanning continues.
- up change takes effect on the next tick only; no effect on the prescaler.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 unconditionally.
  - At SCAN_DIV-1 the digit index advances 0,1,..,DIGITS-1,0.
  - DIGITS=1: index stays 0.
- Display outputs are registered. On the edge after an index change or count change, digit_en=onehot(index) and segments=decode(nibble[index]).
  - Total latency from the count_bcd update to segments reflecting it is 1 cycle.
- Decode (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles >9 cannot occur.
- Leading-zero blanking (BLANK_LZ=1): decade k>0 shows segments=0 when it and all higher decades are 0. digit_en is unaffected.
- Reset mid-operation: immediate return to reset values. No wrap pulse is generated by reset.

Decomposition:
- Shared package holds:
  - seven-segment decode function and segment constants (SEG_BLANK=7'h00);
  - constant function converting MAX_COUNT to its 4*DIGITS BCD image;
  - BCD-valid check function.
- One natural sub-module: bcd_decade, a single decade register with inc/dec, carry-in/borrow-in, carry-out/borrow-out and sync load.
  - Instantiated DIGITS times via generate.
  - The top handles terminal-count override, prescaler, scan and output registers.

Test Plan (DIGITS=2, MAX_COUNT=59, TICK_DIV=4, SCAN_DIV=2, BLANK_LZ=1 unless noted):
- Reset: release rst after 3 cycles -> count_bcd=8'h00, digit_en=2'b01, segments=7'h3F, wrap=0.
- Prescale/carry: en=1, up=1 for 40 cycles -> count advances every 4th cycle to 8'h10; the 09->10 transition carries correctly.
- Wrap up/down:
  - load 8'h59, up=1, one tick -> count 8'h00, wrap high for exactly 1 cycle.
  - Then up=0, one tick -> 8'h59, wrap pulses.
- Load rules:
  - load 8'h6A -> ignored (count unchanged).
  - load 8'h60 -> ignored (>MAX_COUNT).
  - load 8'h42 coincident with a tick -> count 8'h42, no step, prescaler restarts.
- Scan/blank: count 8'h07 -> digit_en alternates 01/10 every 2 cycles; segments=07 on decade 0 and 00 on decade 1. With BLANK_LZ=0, decade 1 shows 3F.
- Async reset mid-count: pull rst low between clk edges at count 8'h37 -> outputs return to reset values immediately, without a clk edge.
